// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the two-requester alu arbiter:
//   DATA_W  - operand/result width of the shared alu (fixed at 4)
//   op_e    - alu opcodes (add, sub, or, xor)
//   state_e - arbiter FSM state encoding (IDLE, EXEC, DONE)
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

   localparam int unsigned DATA_W = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_OR  = 2'b10,
      OP_XOR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage : alu_arbiter_pkg

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu_arbiter_alu
// Shared combinational 4-bit alu. Arithmetic wraps modulo 16; no carry or
// borrow is produced.
// Ports:
//   a, b  in  [3:0]  operands
//   op    in  [1:0]  opcode (see op_e)
//   out   out [3:0]  result
// -----------------------------------------------------------------------------
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [1:0]        op,
   output logic [DATA_W-1:0] out
);

   // Opcode decode; results are truncated to DATA_W so add/sub wrap.
   always_comb begin
      out = {DATA_W{1'b0}};
      case (op)
         OP_ADD:  out = a + b;
         OP_SUB:  out = a - b;
         OP_OR:   out = a | b;
         OP_XOR:  out = a ^ b;
         default: out = {DATA_W{1'b0}};
      endcase
   end

endmodule : alu_arbiter_alu

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Round-robin arbiter sharing one alu between two requesters. A grant in IDLE
// latches the winner's operands, EXEC evaluates the alu from those latched
// registers and captures the result, DONE pulses the owner's done line.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req0/req1         level requests, held until the matching done pulse
//   a0,b0,op0/a1,b1,op1  operands and opcode of each requester
//   done0/done1       one-cycle completion pulse to the owner
//   result            registered alu result, valid while a done is high
//   busy              high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_arbiter
   import alu_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [DATA_W-1:0] a0,
   input  logic [DATA_W-1:0] b0,
   input  logic [1:0]        op0,
   input  logic              req1,
   input  logic [DATA_W-1:0] a1,
   input  logic [DATA_W-1:0] b1,
   input  logic [1:0]        op1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] result,
   output logic              busy
);

   state_e            state_q,  state_d;
   logic              ptr_q,    ptr_d;     // 1'b0 favours requester 0
   logic              owner_q,  owner_d;
   logic [DATA_W-1:0] a_q,      a_d;
   logic [DATA_W-1:0] b_q,      b_d;
   logic [1:0]        op_q,     op_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              done0_q,  done0_d;
   logic              done1_q,  done1_d;
   logic              busy_q,   busy_d;
   logic              winner_s;
   logic [DATA_W-1:0] alu_out_s;

   // The alu only ever sees the latched operands, so input changes after the
   // grant cannot disturb an operation in flight.
   alu_arbiter_alu u_alu (
      .a   (a_q),
      .b   (b_q),
      .op  (op_q),
      .out (alu_out_s)
   );

   // Winner select: a lone request always wins, a tie goes to the pointer.
   always_comb begin
      winner_s = 1'b0;
      if (req0 && req1) begin
         winner_s = ptr_q;
      end else if (req1) begin
         winner_s = 1'b1;
      end else begin
         winner_s = 1'b0;
      end
   end

   // Next-state and next-output computation for every register.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               state_d = ST_EXEC;
               owner_d = winner_s;
               // Point at the requester that did not just win.
               ptr_d   = ~winner_s;
               a_d     = winner_s ? a1  : a0;
               b_d     = winner_s ? b1  : b0;
               op_d    = winner_s ? op1 : op0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            state_d  = ST_DONE;
            result_d = alu_out_s;
            done0_d  = ~owner_q;
            done1_d  = owner_q;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ptr_q    <= 1'b0;
         owner_q  <= 1'b0;
         a_q      <= {DATA_W{1'b0}};
         b_q      <= {DATA_W{1'b0}};
         op_q     <= 2'b00;
         result_q <= {DATA_W{1'b0}};
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         busy_q   <= busy_d;
      end
   end

   assign done0  = done0_q;
   assign done1  = done1_q;
   assign result = result_q;
   assign busy   = busy_q;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. A transaction-level reference model
// tracks when the arbiter is free, who wins each grant (tie goes to whoever
// was not granted last), and when the done pulse and result are due.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [3:0] a0, b0, a1, b1;
   logic [1:0] op0, op1;
   logic       done0, done1, busy;
   logic [3:0] result;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int cyc        = 0;
   int next_free  = 0;
   int g_edge     = -10;
   bit active     = 1'b0;
   bit last_grant = 1'b1;
   bit exp_owner  = 1'b0;
   int exp_res    = 0;
   int hold_res   = 0;

   alu_arbiter dut (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0),
      .a0     (a0),
      .b0     (b0),
      .op0    (op0),
      .req1   (req1),
      .a1     (a1),
      .b1     (b1),
      .op1    (op1),
      .done0  (done0),
      .done1  (done1),
      .result (result),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   function automatic int ref_alu(int x, int y, int op);
      case (op)
         0:       return (x + y) % 16;
         1:       return (x - y + 16) % 16;
         2:       return x | y;
         default: return x ^ y;
      endcase
   endfunction

   task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock edge: model decides on the inputs presented, then the DUT
   // outputs are compared 1 time unit after the edge.
   task automatic step();
      bit win;
      if (rst) begin
         active     = 1'b0;
         last_grant = 1'b1;
         next_free  = cyc + 1;
         hold_res   = 0;
      end else if (cyc >= next_free && (req0 || req1)) begin
         if (req0 && req1) win = ~last_grant;
         else              win = req1;
         last_grant = win;
         exp_owner  = win;
         g_edge     = cyc;
         next_free  = cyc + 3;
         active     = 1'b1;
         exp_res    = win ? ref_alu(int'(a1), int'(b1), int'(op1))
                          : ref_alu(int'(a0), int'(b0), int'(op0));
      end
      @(posedge clk);
      #1;
      if (active && cyc == g_edge + 1) hold_res = exp_res;
      check("done0",  {7'd0, done0},
            {7'd0, (active && cyc == g_edge + 1 && !exp_owner)});
      check("done1",  {7'd0, done1},
            {7'd0, (active && cyc == g_edge + 1 && exp_owner)});
      check("busy",   {7'd0, busy},
            {7'd0, (active && (cyc == g_edge || cyc == g_edge + 1))});
      check("result", {4'd0, result}, 8'(hold_res));
      cyc++;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int vals[4];
      int prev_owner;
      bit hold0;
      vals[0] = 13; vals[1] = 7; vals[2] = 11; vals[3] = 9;

      // Reset state
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      a0 = 4'd0; b0 = 4'd0; op0 = 2'd0; a1 = 4'd0; b1 = 4'd0; op1 = 2'd0;
      run(2);
      check("reset_result", {4'd0, result}, 8'd0);
      rst = 1'b0;
      run(1);

      // 10 op 3 for each opcode on requester 0
      for (int i = 0; i < 4; i++) begin
         req0 = 1'b1; a0 = 4'd10; b0 = 4'd3; op0 = 2'(i);
         run(2);
         check("seq_done0",  {7'd0, done0}, 8'd1);
         check("seq_result", {4'd0, result}, 8'(vals[i]));
         req0 = 1'b0;
         run(1);
      end

      // Wrap cases
      req0 = 1'b1; a0 = 4'd15; b0 = 4'd1; op0 = 2'b00;
      run(2);
      check("wrap_add", {4'd0, result}, 8'd0);
      req0 = 1'b0; run(1);
      req1 = 1'b1; a1 = 4'd3; b1 = 4'd5; op1 = 2'b01;
      run(2);
      check("wrap_sub", {4'd0, result}, 8'd14);
      req1 = 1'b0; run(1);

      // Simultaneous requests after a fresh reset, twice
      rst = 1'b1; run(1); rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req0 = 1'b1; a0 = 4'd1; b0 = 4'd2; op0 = 2'b00;
         req1 = 1'b1; a1 = 4'd6; b1 = 4'd5; op1 = 2'b11;
         run(2);
         check("pair_first0", {7'd0, done0}, 8'd1);
         req0 = 1'b0;
         run(3);
         check("pair_then1",  {7'd0, done1}, 8'd1);
         check("pair_res1",   {4'd0, result}, 8'd3);
         req1 = 1'b0;
         run(1);
      end

      // Operand changes during EXEC do not affect the latched operation
      req0 = 1'b1; a0 = 4'd2; b0 = 4'd3; op0 = 2'b00;
      run(1);
      a0 = 4'd9; op0 = 2'b11;
      run(1);
      check("latched_res", {4'd0, result}, 8'd5);
      req0 = 1'b0; run(1);

      // Reset during EXEC aborts, then a new request completes
      req0 = 1'b1; a0 = 4'd4; b0 = 4'd4; op0 = 2'b00;
      run(1);
      rst = 1'b1;
      run(1);
      check("abort_done0", {7'd0, done0}, 8'd0);
      check("abort_busy",  {7'd0, busy},  8'd0);
      check("abort_res",   {4'd0, result}, 8'd0);
      rst = 1'b0;
      run(2);
      check("after_abort", {4'd0, result}, 8'd8);
      req0 = 1'b0; run(1);

      // req1 held while req0 pulses: done owners must alternate
      prev_owner = -1;
      hold0 = 1'b1;
      req1 = 1'b1; a1 = 4'd7; b1 = 4'd1; op1 = 2'b10;
      for (int i = 0; i < 24; i++) begin
         req0 = hold0; a0 = 4'(i); b0 = 4'd2; op0 = 2'(i);
         step();
         hold0 = 1'b1;
         if (done0 || done1) begin
            if (prev_owner >= 0) check("alternate", {7'd0, done1}, 8'(1 - prev_owner));
            prev_owner = done1 ? 1 : 0;
            if (done0) hold0 = 1'b0;
         end
      end
      req0 = 1'b0; req1 = 1'b0; run(3);

      // Random traffic, including mid-operation input churn and resets
      for (int i = 0; i < 400; i++) begin
         rst  = ($urandom_range(0, 39) == 0);
         req0 = 1'($urandom);
         req1 = 1'($urandom);
         a0 = 4'($urandom); b0 = 4'($urandom); op0 = 2'($urandom);
         a1 = 4'($urandom); b1 = 4'($urandom); op1 = 2'($urandom);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_alu_arbiter
